// File: rtl/mii_pkg.sv
// Shared MII receive/transmit constants: FSM state encoding, nibble codes and CRC-32 constants.
package mii_pkg;

  localparam logic [1:0] RX_ST_IDLE     = 2'd0;
  localparam logic [1:0] RX_ST_PREAMBLE = 2'd1;
  localparam logic [1:0] RX_ST_DATA     = 2'd2;
  localparam logic [1:0] RX_ST_DROP     = 2'd3;

  typedef enum logic [1:0] {
    RX_IDLE     = RX_ST_IDLE,
    RX_PREAMBLE = RX_ST_PREAMBLE,
    RX_DATA     = RX_ST_DATA,
    RX_DROP     = RX_ST_DROP
  } rx_state_t;

  localparam logic [3:0]  MII_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  MII_SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC32_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE    = 32'hC704DD7B;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The LSB-first shift register holds the residue in bit-reversed order.
  localparam logic [31:0] CRC32_RESIDUE_LSB = bitrev32(CRC32_RESIDUE);

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational reflected CRC-32 update over one byte, LSB first.
module eth_crc32_d8
  import mii_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    o_crc = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      o_crc = o_crc[0] ? ((o_crc >> 1) ^ CRC32_POLY) : (o_crc >> 1);
    end
  end

endmodule

// File: rtl/mii_rx_decoder.sv
// MII receive decoder: strips preamble/SFD, packs nibbles into bytes, checks FCS and length.
// Bytes appear one cycle after the high nibble is sampled; no backpressure.
module mii_rx_decoder
  import mii_pkg::*;
#(
  parameter int MIN_PREAMBLE = 8,
  parameter int MIN_BYTES    = 64,
  parameter int MAX_BYTES    = 1518
) (
  input  logic        enet_rx_clk,
  input  logic        i_reset,
  input  logic        enet_rx_dv,
  input  logic [3:0]  enet_rx_data,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_eof,
  output logic [15:0] o_len,
  output logic        o_crc_ok,
  output logic        o_err_align,
  output logic        o_err_len
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_BYTES);
  localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

  rx_state_t   r_state;
  logic [3:0]  r_pre_cnt;
  logic [3:0]  r_low;
  logic        r_phase;
  logic [15:0] r_cnt;
  logic [31:0] r_crc;
  logic [31:0] w_crc_next;
  logic [7:0]  w_byte;
  logic        w_pre_ok;

  assign w_byte   = {enet_rx_data, r_low};
  assign w_pre_ok = {28'd0, r_pre_cnt} >= 32'(MIN_PREAMBLE);

  eth_crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_byte),
    .o_crc  (w_crc_next)
  );

  always_ff @(posedge enet_rx_clk) begin
    if (i_reset) begin
      // Starting in DROP discards any frame already in flight until dv drops.
      r_state     <= RX_DROP;
      r_pre_cnt   <= 4'd0;
      r_low       <= 4'd0;
      r_phase     <= 1'b0;
      r_cnt       <= 16'd0;
      r_crc       <= 32'hFFFFFFFF;
      o_valid     <= 1'b0;
      o_data      <= 8'd0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_len       <= 16'd0;
      o_crc_ok    <= 1'b0;
      o_err_align <= 1'b0;
      o_err_len   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (enet_rx_dv) begin
            if (enet_rx_data == MII_PREAMBLE_NIB) begin
              r_state   <= RX_PREAMBLE;
              r_pre_cnt <= 4'd1;
            end else begin
              r_state <= RX_DROP;
            end
          end
        end
        RX_PREAMBLE: begin
          if (!enet_rx_dv) begin
            r_state <= RX_IDLE;
          end else if (enet_rx_data == MII_PREAMBLE_NIB) begin
            if (r_pre_cnt != 4'hF) r_pre_cnt <= r_pre_cnt + 4'd1;
          end else if (enet_rx_data == MII_SFD_NIB && w_pre_ok) begin
            r_state <= RX_DATA;
            r_crc   <= 32'hFFFFFFFF;
            r_cnt   <= 16'd0;
            r_phase <= 1'b0;
          end else begin
            r_state <= RX_DROP;
          end
        end
        RX_DATA: begin
          if (!enet_rx_dv) begin
            r_state     <= RX_IDLE;
            o_eof       <= 1'b1;
            o_len       <= r_cnt;
            o_crc_ok    <= (r_crc == CRC32_RESIDUE_LSB);
            o_err_align <= r_phase;
            o_err_len   <= (r_cnt < MIN_LEN) || (r_cnt > MAX_LEN);
          end else if (!r_phase) begin
            r_low   <= enet_rx_data;
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_crc   <= w_crc_next;
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            // Oversized frames keep counting and CRC-ing but stop emitting.
            if (r_cnt < MAX_LEN) begin
              o_valid <= 1'b1;
              o_data  <= w_byte;
              o_sof   <= (r_cnt == 16'd0);
            end
          end
        end
        default: begin
          if (!enet_rx_dv) r_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mii_rx_decoder.sv
// Directed bench for mii_rx_decoder: table of frames plus a hand-written mid-frame reset sequence.
module tb_mii_rx_decoder;

  localparam int MAXB = 1518;

  typedef struct {
    int         pre;
    logic [3:0] sfd;
    int         bad_pos;
    int         nbytes;
    int         flip;
    bit         extra;
    int         gap;
    int         exp_nv;
    bit         exp_eof;
    logic [15:0] exp_len;
    bit         exp_crc;
    bit         exp_align;
    bit         exp_elen;
  } vec_t;

  logic        enet_rx_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        enet_rx_dv = 1'b0;
  logic [3:0]  enet_rx_data = 4'h0;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_sof;
  logic        o_eof;
  logic [15:0] o_len;
  logic        o_crc_ok;
  logic        o_err_align;
  logic        o_err_len;

  int n_chk = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_eof = 0;

  logic        exp_v = 1'b0;
  logic        exp_s = 1'b0;
  logic        exp_e = 1'b0;
  logic [7:0]  exp_b = 8'h00;
  logic [15:0] e_len = 16'd0;
  logic        e_crc = 1'b0;
  logic        e_al = 1'b0;
  logic        e_el = 1'b0;
  logic [7:0]  fr [0:2047];

  always #5 enet_rx_clk = ~enet_rx_clk;

  mii_rx_decoder dut (
    .enet_rx_clk  (enet_rx_clk),
    .i_reset      (i_reset),
    .enet_rx_dv   (enet_rx_dv),
    .enet_rx_data (enet_rx_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_sof        (o_sof),
    .o_eof        (o_eof),
    .o_len        (o_len),
    .o_crc_ok     (o_crc_ok),
    .o_err_align  (o_err_align),
    .o_err_len    (o_err_len)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Expectation flags are set by the driver just after a falling edge and judged at the next one.
  always @(negedge enet_rx_clk) begin
    if (o_valid) n_valid++;
    if (o_eof) n_eof++;
    if (exp_v || o_valid)
      chk("byte", {22'd0, o_valid, o_sof, o_data}, {22'd0, exp_v, exp_s, exp_b});
    else if (o_sof)
      chk("sof_alone", {31'd0, o_sof}, 32'd0);
    if (exp_e || o_eof)
      chk("eof", {11'd0, o_eof, o_valid, o_crc_ok, o_err_align, o_err_len, o_len},
                 {11'd0, exp_e, 1'b0, e_crc, e_al, e_el, e_len});
  end

  task automatic drive(input logic rst, input logic dv, input logic [3:0] d,
                       input logic ev, input logic [7:0] eb, input logic es, input logic ee);
    @(negedge enet_rx_clk);
    #1;
    i_reset = rst; enet_rx_dv = dv; enet_rx_data = d;
    exp_v = ev; exp_b = eb; exp_s = es; exp_e = ee;
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input int nbytes, input int flip, input int seed);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < nbytes - 4; i++) begin
      fr[i] = 8'(i * 29 + seed * 13 + 7);
      c = crc_byte(c, fr[i]);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) fr[nbytes - 4 + j] = c[8*j +: 8];
    if (flip >= 0) fr[flip] = fr[flip] ^ 8'h01;
  endtask

  task automatic send_frame(input vec_t v, input int idx);
    logic acc;
    int nv0, ne0;
    acc = v.exp_eof;
    build(v.nbytes, v.flip, idx);
    e_len = v.exp_len; e_crc = v.exp_crc; e_al = v.exp_align; e_el = v.exp_elen;
    nv0 = n_valid; ne0 = n_eof;
    for (int p = 0; p < v.pre; p++)
      drive(1'b0, 1'b1, (p == v.bad_pos) ? 4'h3 : 4'h5, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, v.sfd, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < v.nbytes; i++) begin
      drive(1'b0, 1'b1, fr[i][3:0], 1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 1'b1, fr[i][7:4], acc && (i < MAXB), fr[i], acc && (i == 0), 1'b0);
    end
    if (v.extra) drive(1'b0, 1'b1, 4'hA, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int g = 0; g < v.gap; g++)
      drive(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, acc && (g == 0));
    #2;
    chk($sformatf("v%0d_nvalid", idx), n_valid - nv0, v.exp_nv);
    chk($sformatf("v%0d_neof", idx), n_eof - ne0, {31'd0, acc});
    if (acc) chk($sformatf("v%0d_len_hold", idx), {16'd0, o_len}, {16'd0, v.exp_len});
  endtask

  vec_t vt [14];
  int nv0;

  initial begin
    vt[0]  = '{15, 4'hD, -1, 64,   -1, 0, 2, 64,   1, 16'd64,   1, 0, 0};
    vt[1]  = '{15, 4'hD, -1, 64,   10, 0, 2, 64,   1, 16'd64,   0, 0, 0};
    vt[2]  = '{15, 4'hD, -1, 64,   -1, 1, 2, 64,   1, 16'd64,   1, 1, 0};
    vt[3]  = '{4,  4'hD, -1, 64,   -1, 0, 1, 0,    0, 16'd0,    0, 0, 0};
    vt[4]  = '{15, 4'hD, -1, 64,   -1, 0, 2, 64,   1, 16'd64,   1, 0, 0};
    vt[5]  = '{15, 4'hD, 6,  64,   -1, 0, 1, 0,    0, 16'd0,    0, 0, 0};
    vt[6]  = '{15, 4'hD, -1, 64,   -1, 0, 2, 64,   1, 16'd64,   1, 0, 0};
    vt[7]  = '{8,  4'hD, -1, 64,   -1, 0, 2, 64,   1, 16'd64,   1, 0, 0};
    vt[8]  = '{7,  4'hD, -1, 64,   -1, 0, 2, 0,    0, 16'd0,    0, 0, 0};
    vt[9]  = '{15, 4'hD, -1, 1520, -1, 0, 2, 1518, 1, 16'd1520, 1, 0, 1};
    vt[10] = '{15, 4'hD, -1, 1518, -1, 0, 2, 1518, 1, 16'd1518, 1, 0, 0};
    vt[11] = '{15, 4'hD, -1, 40,   -1, 0, 2, 40,   1, 16'd40,   1, 0, 1};
    vt[12] = '{15, 4'hD, -1, 63,   -1, 0, 2, 63,   1, 16'd63,   1, 0, 1};
    vt[13] = '{15, 4'hD, -1, 65,   -1, 0, 2, 65,   1, 16'd65,   1, 0, 0};

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    chk("rst_flags", {26'd0, o_valid, o_sof, o_eof, o_crc_ok, o_err_align, o_err_len}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_len", {16'd0, o_len}, 32'd0);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) send_frame(vt[i], i);

    // Reset pulse while byte 20 is on the wire: status clears and the frame tail is ignored.
    build(64, -1, 99);
    nv0 = n_valid;
    for (int p = 0; p < 15; p++) drive(1'b0, 1'b1, 4'h5, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hD, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, fr[i][3:0], 1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 1'b1, fr[i][7:4], 1'b1, fr[i], i == 0, 1'b0);
    end
    drive(1'b1, 1'b1, fr[20][3:0], 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, fr[20][7:4], 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    chk("midrst_flags", {26'd0, o_valid, o_sof, o_eof, o_crc_ok, o_err_align, o_err_len}, 32'd0);
    chk("midrst_len", {16'd0, o_len}, 32'd0);
    for (int i = 21; i < 64; i++) begin
      drive(1'b0, 1'b1, fr[i][3:0], 1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 1'b1, fr[i][7:4], 1'b0, 8'h00, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    chk("midrst_nvalid", n_valid - nv0, 32'd20);
    chk("midrst_len_hold", {16'd0, o_len}, 32'd0);
    send_frame(vt[0], 20);

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
